// File: rtl/cgra_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cgra_ctrl_pkg
// Shared definitions for the CGRA configuration sequencer: geometry
// parameters, command opcodes, FSM state encoding and the header byte layout.
// ---------------------------------------------------------------------------
package cgra_ctrl_pkg;

    localparam int N_TILES    = 4;
    localparam int CFG_WORDS  = 4;
    localparam int DATA_WIDTH = 8;

    localparam int TILE_W    = $clog2(N_TILES);
    localparam int ADDR_W    = $clog2(CFG_WORDS);
    // One extra bit so a length byte of 0 can stand for a full 256-cycle run.
    localparam int RUN_CNT_W = DATA_WIDTH + 1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_FLUSH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN_LEN = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // Header byte: op in [7:6], tile in [5:4], arg in [3:0].
    typedef struct packed {
        logic [1:0]         op;
        logic [TILE_W-1:0]  tile;
        logic [N_TILES-1:0] arg;
    } header_t;

endpackage

// File: rtl/cgra_run_timer.sv
// ---------------------------------------------------------------------------
// cgra_run_timer
// Run-length down counter. A length byte of 0 loads a full 256-cycle run.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   load_i      load len_i into the counter
//   len_i       run length byte (0 means 256)
//   dec_i       decrement by one this cycle (ignored once the counter is 0)
//   last_o      counter is on its final cycle
// ---------------------------------------------------------------------------
module cgra_run_timer
    import cgra_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] len_i,
    input  logic       dec_i,
    output logic       last_o
);

    logic [RUN_CNT_W-1:0] cnt_q;
    logic [RUN_CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (len_i == '0) ? RUN_CNT_W'(256) : RUN_CNT_W'(len_i);
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - RUN_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == RUN_CNT_W'(1));

endmodule

// File: rtl/cgra_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// cgra_cfg_sequencer
// Byte-serial configuration loader and run scheduler for the 2x2 CGRA.
// Parses header + payload bytes, emits per-tile config writes, runs a tile
// mask for a programmed number of cycles and pulses the NoC FIFO flush.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   ena                 design enable; low freezes FSM and counters
//   in_valid, in_data   command byte stream
//   in_ready            byte accepted when in_valid && in_ready
//   cfg_we              one-cycle config write strobe
//   cfg_tile/addr/data  write target tile, word index and value
//   tile_en             per-tile compute enable (forced 0 while ena is low)
//   fifo_flush          one-cycle NoC FIFO clear pulse
//   busy                FSM is not idle
//   done                one-cycle pulse after a run completes
//   err                 one-cycle pulse on a RUN header with an empty mask
// ---------------------------------------------------------------------------
module cgra_cfg_sequencer
    import cgra_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       cfg_we,
    output logic [1:0] cfg_tile,
    output logic [1:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic [3:0] tile_en,
    output logic       fifo_flush,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e               state_q;
    logic [TILE_W-1:0]    tile_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W-1:0]    rem_q;      // payload bytes still expected, minus one
    logic [N_TILES-1:0]   mask_q;

    logic                 cfg_we_q;
    logic [TILE_W-1:0]    cfg_tile_q;
    logic [ADDR_W-1:0]    cfg_addr_q;
    logic [7:0]           cfg_data_q;
    logic [N_TILES-1:0]   tile_en_q;
    logic                 fifo_flush_q;
    logic                 done_q;
    logic                 err_q;

    logic                 accept;
    logic                 timer_last;
    header_t              hdr;

    assign in_ready = ena && (state_q != ST_RUN);
    assign accept   = in_valid && in_ready;
    assign hdr      = header_t'(in_data);

    cgra_run_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept && state_q == ST_RUN_LEN),
        .len_i  (in_data),
        .dec_i  (ena && state_q == ST_RUN),
        .last_o (timer_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tile_q       <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            mask_q       <= '0;
            cfg_we_q     <= 1'b0;
            cfg_tile_q   <= '0;
            cfg_addr_q   <= '0;
            cfg_data_q   <= '0;
            tile_en_q    <= '0;
            fifo_flush_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // Strobes last one cycle even if ena drops right after they fire.
            cfg_we_q     <= 1'b0;
            fifo_flush_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;

            if (ena) begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            case (hdr.op)
                                OP_LOAD: begin
                                    tile_q  <= hdr.tile;
                                    addr_q  <= hdr.arg[1:0];
                                    rem_q   <= hdr.arg[3:2];
                                    state_q <= ST_LOAD;
                                end
                                OP_RUN: begin
                                    if (hdr.arg == '0) begin
                                        err_q <= 1'b1;
                                    end else begin
                                        mask_q  <= hdr.arg;
                                        state_q <= ST_RUN_LEN;
                                    end
                                end
                                OP_FLUSH: fifo_flush_q <= 1'b1;
                                OP_NOP:   ;
                                default:  ;
                            endcase
                        end
                    end
                    ST_LOAD: begin
                        if (accept) begin
                            cfg_we_q   <= 1'b1;
                            cfg_tile_q <= tile_q;
                            cfg_addr_q <= addr_q;
                            cfg_data_q <= in_data;
                            addr_q     <= addr_q + ADDR_W'(1);
                            rem_q      <= rem_q - ADDR_W'(1);
                            if (rem_q == '0) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                    ST_RUN_LEN: begin
                        if (accept) begin
                            tile_en_q <= mask_q;
                            state_q   <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (timer_last) begin
                            tile_en_q <= '0;
                            done_q    <= 1'b1;
                            state_q   <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cfg_we     = cfg_we_q;
    assign cfg_tile   = cfg_tile_q;
    assign cfg_addr   = cfg_addr_q;
    assign cfg_data   = cfg_data_q;
    // A paused run must not compute, so the enable is masked without delay.
    assign tile_en    = tile_en_q & {N_TILES{ena}};
    assign fifo_flush = fifo_flush_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule
